// File: rtl/sprite_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_compositor : maps OLED pixels into sprite ROM space and runs punch FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module sprite_compositor #(
  parameter int          WIDTH           = 96,
  parameter int          HEIGHT          = 64,
  parameter int          FRAMES_PER_STEP = 4,
  parameter logic [15:0] TRANSPARENT     = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  output logic [15:0] pixel_data,
  input  logic [7:0]  sprite_x,
  input  logic [6:0]  sprite_y,
  input  logic        flip,
  input  logic        anim_req,
  input  logic [15:0] bg_colour,
  output logic [12:0] rom_index,
  input  logic [15:0] rom_colour,
  output logic [1:0]  frame_sel,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDUP  = 2'd1,
    PUNCH   = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam int            CW   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_sh_x;
  logic [6:0]      r_sh_y;
  logic            r_sh_flip;
  logic            r_in_win_q;

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      WINDUP:  sel_of = 2'd1;
      PUNCH:   sel_of = 2'd2;
      RECOVER: sel_of = 2'd1;
      default: sel_of = 2'd0;
    endcase
  endfunction

  // frame_sel captures the pre-update state so the new state shows next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      frame_sel <= 2'd0;
      busy      <= 1'b0;
      r_sh_x    <= '0;
      r_sh_y    <= '0;
      r_sh_flip <= 1'b0;
    end else begin
      if (frame_begin) begin
        r_sh_x    <= sprite_x;
        r_sh_y    <= sprite_y;
        r_sh_flip <= flip;
        frame_sel <= sel_of(r_state);
      end
      case (r_state)
        IDLE: begin
          if (anim_req) begin
            r_state <= WINDUP;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          if (frame_begin) begin
            if (r_cnt == LAST) begin
              r_cnt <= '0;
              case (r_state)
                WINDUP:  r_state <= PUNCH;
                PUNCH:   r_state <= RECOVER;
                default: begin
                  r_state <= IDLE;
                  busy    <= 1'b0;
                end
              endcase
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  logic [8:0]  w_x, w_y, w_rel_x, w_rel_y, w_src_x;
  logic        w_in_win;
  logic [12:0] w_rom_index;

  // 9-bit two's complement differences; bit 8 set means left of / above the sprite
  assign w_x      = 9'(pixel_index % 13'(WIDTH));
  assign w_y      = 9'(pixel_index / 13'(WIDTH));
  assign w_rel_x  = w_x - {r_sh_x[7], r_sh_x};
  assign w_rel_y  = w_y - {{2{r_sh_y[6]}}, r_sh_y};
  assign w_in_win = (pixel_index < 13'(WIDTH * HEIGHT))
                  && !w_rel_x[8] && (w_rel_x < 9'(WIDTH))
                  && !w_rel_y[8] && (w_rel_y < 9'(HEIGHT));
  assign w_src_x  = r_sh_flip ? (9'(WIDTH - 1) - w_rel_x) : w_rel_x;
  assign w_rom_index = ({4'b0, w_rel_y} * 13'(WIDTH)) + {4'b0, w_src_x};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_index  <= '0;
      r_in_win_q <= 1'b0;
      pixel_data <= '0;
    end else begin
      rom_index  <= w_in_win ? w_rom_index : 13'd0;
      r_in_win_q <= w_in_win;
      pixel_data <= (!r_in_win_q || rom_colour == TRANSPARENT) ? bg_colour : rom_colour;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sprite_compositor : randomized bench with a behavioural window/anim model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sprite_compositor;
  localparam int W   = 96;
  localparam int H   = 64;
  localparam int FPS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic [12:0] pixel_index = '0;
  logic [15:0] pixel_data;
  logic [7:0]  sprite_x = '0;
  logic [6:0]  sprite_y = '0;
  logic        flip = 1'b0;
  logic        anim_req = 1'b0;
  logic [15:0] bg_colour = '0;
  logic [12:0] rom_index;
  logic [15:0] rom_colour;
  logic [1:0]  frame_sel;
  logic        busy;

  int total = 0;
  int bad   = 0;

  bit          rom_force_en = 1'b0;
  logic [15:0] rom_force = '0;

  int   m_sx = 0, m_sy = 0, m_k = 0;
  bit   m_fl = 1'b0, m_busy = 1'b0;
  logic [1:0] m_sel = 2'd0;

  always #5 clk = ~clk;

  sprite_compositor #(
    .WIDTH(W), .HEIGHT(H), .FRAMES_PER_STEP(FPS), .TRANSPARENT(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .pixel_index(pixel_index),
    .pixel_data(pixel_data), .sprite_x(sprite_x), .sprite_y(sprite_y), .flip(flip),
    .anim_req(anim_req), .bg_colour(bg_colour), .rom_index(rom_index),
    .rom_colour(rom_colour), .frame_sel(frame_sel), .busy(busy)
  );

  // ROM stub: every fifth entry is transparent, the rest a nonzero hash
  function automatic logic [15:0] rom_fn(input int i);
    if (i % 5 == 0) return 16'h0000;
    return 16'((i * 40503) ^ 23130) | 16'h0001;
  endfunction

  assign rom_colour = rom_force_en ? rom_force : rom_fn(int'(rom_index));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // sel shown during frame k of an animation: windup, punch, recover
  function automatic logic [1:0] sel_for(input int k);
    return ((k / FPS) == 1) ? 2'd2 : 2'd1;
  endfunction

  task automatic clk_cycle(input bit fb, input bit req);
    bit was_busy;
    frame_begin = fb;
    anim_req    = req;
    @(posedge clk);
    was_busy = m_busy;
    if (fb) begin
      m_sx = int'($signed(sprite_x));
      m_sy = int'($signed(sprite_y));
      m_fl = flip;
      if (was_busy) begin
        m_sel = sel_for(m_k);
        m_k++;
        if (m_k == 3 * FPS) m_busy = 1'b0;
      end else begin
        m_sel = 2'd0;
      end
    end
    if (req && !was_busy) begin
      m_busy = 1'b1;
      m_k    = 0;
    end
    @(negedge clk);
    frame_begin = 1'b0;
    anim_req    = 1'b0;
  endtask

  task automatic check_anim(input string tag);
    check({tag, "_sel"}, 32'(frame_sel), 32'(m_sel));
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
  endtask

  task automatic pix(input int p, output int got_idx);
    int x, y, rx, ry, idx;
    bit inw;
    logic [15:0] c, exp_pd;
    pixel_index = 13'(p);
    x = p % W;
    y = p / W;
    rx = x - m_sx;
    ry = y - m_sy;
    inw = (p < W * H) && rx >= 0 && rx < W && ry >= 0 && ry < H;
    idx = inw ? ry * W + (m_fl ? (W - 1 - rx) : rx) : 0;
    clk_cycle(1'b0, 1'b0);
    got_idx = int'(rom_index);
    check("rom_index", 32'(rom_index), 32'(idx));
    clk_cycle(1'b0, 1'b0);
    c = rom_force_en ? rom_force : rom_fn(idx);
    exp_pd = (!inw || c == 16'h0000) ? bg_colour : c;
    check("pixel_data", 32'(pixel_data), 32'(exp_pd));
  endtask

  task automatic set_sprite(input int sx, input int sy, input bit fl);
    sprite_x = 8'(sx);
    sprite_y = 7'(sy);
    flip     = fl;
  endtask

  initial begin
    int gi;
    logic [1:0] exp6 [13] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                              2'd1, 2'd1, 2'd1, 2'd1, 2'd0};

    #1;
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_rom_index", 32'(rom_index), 32'h0);
    check("rst_frame_sel", 32'(frame_sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of an animation
    bg_colour = 16'hF800;
    clk_cycle(1'b0, 1'b1);
    repeat (5) clk_cycle(1'b1, 1'b0);
    check_anim("pre_rst");
    check("pre_rst_pd", 32'(pixel_data), 32'hF800);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'h0);
    check("async_sel", 32'(frame_sel), 32'h0);
    check("async_pd", 32'(pixel_data), 32'h0);
    m_sx = 0; m_sy = 0; m_fl = 1'b0; m_busy = 1'b0; m_k = 0; m_sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // straight mapping, then flip latched at frame_begin
    set_sprite(0, 0, 1'b0);
    clk_cycle(1'b1, 1'b0);
    pix(1868, gi);
    check("plain_idx", 32'(gi), 32'd1868);
    set_sprite(0, 0, 1'b1);
    clk_cycle(1'b1, 1'b0);
    pix(1868, gi);
    check("flip_idx", 32'(gi), 32'd1875);

    // horizontal offset: left of sprite shows background
    set_sprite(10, 0, 1'b0);
    bg_colour = 16'h001F;
    clk_cycle(1'b1, 1'b0);
    pix(5, gi);
    check("off_left_pd", 32'(pixel_data), 32'h001F);
    pix(15, gi);
    check("off_in_idx", 32'(gi), 32'd5);

    // transparency keying
    set_sprite(0, 0, 1'b0);
    clk_cycle(1'b1, 1'b0);
    rom_force_en = 1'b1;
    bg_colour = 16'hF800;
    rom_force = 16'h0000;
    pix(100, gi);
    check("transp_pd", 32'(pixel_data), 32'hF800);
    rom_force = 16'hFFFF;
    pix(100, gi);
    check("opaque_pd", 32'(pixel_data), 32'hFFFF);
    rom_force_en = 1'b0;
    pix(6200, gi);

    // full animation sequence
    clk_cycle(1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      clk_cycle(1'b1, (i == 2));
      check("seq_sel", 32'(frame_sel), 32'(exp6[i]));
      check("seq_busy", 32'(busy), 32'(i < 11));
      check_anim("seq_model");
    end

    // request coinciding with frame_begin while idle
    clk_cycle(1'b1, 1'b1);
    check_anim("coinc");

    // randomized positions, pixels and animation requests
    repeat (150) begin
      set_sprite(int'($urandom_range(0, 191)) - 96, int'($urandom_range(0, 127)) - 64,
                 1'($urandom_range(0, 1)));
      bg_colour = 16'($urandom);
      clk_cycle(1'b1, ($urandom_range(0, 3) == 0));
      check_anim("rnd_fb");
      clk_cycle(1'b0, ($urandom_range(0, 3) == 0));
      check_anim("rnd_nofb");
      repeat (3) pix(int'($urandom_range(0, 6400)), gi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
